mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the RV32I pipeline. Consumes the registered EX/MEM outputs (address, store data, control), runs a request/response handshake on the data-memory bus, and formats load data (byte-lane select, sign/zero extension) for the MEM/WB register. Asserts a stall to freeze the pipeline while an access is outstanding.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/mem_lsu_if.sv | 25 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_lsu.sv | 142 ++++++++++++++
 tb/tb_mem_lsu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I types and constants for the MEM-stage load/store unit
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 011/110/111 have no RV32I load/store meaning; they complete as no-ops
    function automatic logic f3_legal(input logic [2:0] f3);
        return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-memory request/response bus between the LSU and memory
interface mem_lsu_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ready;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable generation, store lane replication, load extract/extend
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);
    logic [XLEN-1:0] byte_lane;
    logic [XLEN-1:0] half_lane;

    // store side: size comes from funct3[1:0]; offsets below the access size are dropped
    always_comb begin
        be    = 4'b1111;
        wdata = wd;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{wd[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd;
            end
        endcase
    end

    // load side: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        byte_lane = rdata >> {offset, 3'b000};
        half_lane = rdata >> {offset[1], 4'b0000};
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane[15:0]};
            F3_BU:   load_data = {24'd0, byte_lane[7:0]};
            F3_HU:   load_data = {16'd0, half_lane[15:0]};
            default: load_data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit FSM; optional LSU_MISALIGN_CHECK_EN
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    mem_lsu_if.master       dmem
);
    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            mis_q, mis_d;

    logic            access;
    logic            legal;
    logic            misaligned;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_load;

    assign access = MemReadM | MemWriteM;
    assign legal  = f3_legal(Funct3M);

`ifdef LSU_MISALIGN_CHECK_EN
    // halfwords need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        case (Funct3M[1:0])
            2'b01:   misaligned = ALUResultM[0];
            2'b10:   misaligned = |ALUResultM[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (Funct3M),
        .offset    (ALUResultM[1:0]),
        .wd        (WriteDataM),
        .rdata     (dmem.dmem_rdata),
        .be        (al_be),
        .wdata     (al_wdata),
        .load_data (al_load)
    );

    // next-state logic; bus fields are captured on entry to REQ and zeroed on acceptance
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (!legal || misaligned) begin
                        state_d = DONE;
                        mis_d   = legal & misaligned;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
                        wdata_d = al_wdata;
                        be_d    = al_be;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_ready) begin
                    state_d = we_q ? DONE : RESP;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = 4'b0000;
                end
            end
            RESP: begin
                if (dmem.dmem_rvalid) begin
                    rdata_d = al_load;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                mis_d   = 1'b0;
            end
        endcase
    end

    // state and registered outputs; asynchronous reset returns everything to idle/zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
        end
    end

    assign StallM          = access & (state_q != DONE);
    assign ReadDataM       = rdata_q;
    assign MisalignM       = mis_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;

    mem_lsu_if #(.XLEN(32)) dmem_bus ();

    mem_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .dmem       (dmem_bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total  = 0;
    int n_passed = 0;

    int          stalls;
    bit          req_seen, stable, timed_out;
    logic [31:0] obs_addr, obs_wdata, done_rdata;
    logic [3:0]  obs_be;
    logic        obs_we, done_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_passed++;
    endtask

    // run one access; called just after a negedge, returns one negedge after the DONE cycle
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                             input int rdy_wait, input int rv_wait);
        int  rq, rs;
        bit  accepted, given;
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        stalls = 0; req_seen = 0; stable = 1; timed_out = 1;
        rq = 0; rs = 0; accepted = 0; given = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            dmem_bus.dmem_ready  = 1'b0;
            dmem_bus.dmem_rvalid = 1'b0;
            if (dmem_bus.dmem_req) begin
                if (!req_seen) begin
                    obs_addr  = dmem_bus.dmem_addr;
                    obs_be    = dmem_bus.dmem_be;
                    obs_wdata = dmem_bus.dmem_wdata;
                    obs_we    = dmem_bus.dmem_we;
                end else if (obs_addr !== dmem_bus.dmem_addr || obs_be !== dmem_bus.dmem_be ||
                             obs_wdata !== dmem_bus.dmem_wdata || obs_we !== dmem_bus.dmem_we) begin
                    stable = 0;
                end
                req_seen = 1;
                if (rq >= rdy_wait) begin
                    dmem_bus.dmem_ready = 1'b1;
                    accepted = 1;
                end
                rq++;
            end else if (accepted && rd && !wr && !given) begin
                if (rs >= rv_wait) begin
                    dmem_bus.dmem_rvalid = 1'b1;
                    dmem_bus.dmem_rdata  = rdat;
                    given = 1;
                end
                rs++;
            end
            if (!StallM) begin
                done_rdata = ReadDataM;
                done_mis   = MisalignM;
                timed_out  = 0;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        chk("timeout", {31'd0, timed_out}, 32'd0);
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        dmem_bus.dmem_ready  = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0;
        dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_mis", {31'd0, MisalignM}, 32'd0);
        chk("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rst_addr", dmem_bus.dmem_addr, 32'h0);
        chk("rst_be", {28'd0, dmem_bus.dmem_be}, 32'h0);
        chk("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("nonmem_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);

        // LB 0x103, lane 3 = 0x80 -> sign-extended
        do_access(1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
        chk("lb_data", done_rdata, 32'hFFFF_FF80);
        chk("lb_stall", stalls, 3);
        chk("lb_addr", obs_addr, 32'h100);
        chk("lb_be", {28'd0, obs_be}, 32'h8);

        // LHU 0x202, upper half
        do_access(1, 0, F3_HU, 32'h202, 32'h0, 32'hBEEF_0000, 0, 0);
        chk("lhu_data", done_rdata, 32'h0000_BEEF);
        chk("lhu_be", {28'd0, obs_be}, 32'hC);
        chk("lhu_addr", obs_addr, 32'h200);
        chk("lhu_stall", stalls, 3);

        // SB 0xAB at 0x301 with ready withheld 3 cycles
        do_access(0, 1, F3_B, 32'h301, 32'h0000_00AB, 32'h0, 3, 0);
        chk("sb_be", {28'd0, obs_be}, 32'h2);
        chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        chk("sb_we", {31'd0, obs_we}, 32'd1);
        chk("sb_stable", {31'd0, stable}, 32'd1);
        chk("sb_stall", stalls, 5);
        chk("sb_keep_rd", done_rdata, 32'h0000_BEEF);

        // SW at misaligned 0x402
        do_access(0, 1, F3_W, 32'h402, 32'h1122_3344, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("sw_noreq", {31'd0, req_seen}, 32'd0);
        chk("sw_mis", {31'd0, done_mis}, 32'd1);
        chk("sw_stall", stalls, 1);
`else
        chk("sw_req", {31'd0, req_seen}, 32'd1);
        chk("sw_be", {28'd0, obs_be}, 32'hF);
        chk("sw_addr", obs_addr, 32'h400);
        chk("sw_wdata", obs_wdata, 32'h1122_3344);
        chk("sw_mis", {31'd0, done_mis}, 32'd0);
        chk("sw_stall", stalls, 2);
`endif
        #1;
        chk("sw_mis_clr", {31'd0, MisalignM}, 32'd0);
        chk("sw_keep_rd", ReadDataM, 32'h0000_BEEF);

        // LH 0x106 with rvalid delayed 2 cycles
        do_access(1, 0, F3_H, 32'h106, 32'h0, 32'h8001_7FFF, 0, 2);
        chk("lh_data", done_rdata, 32'hFFFF_8001);
        chk("lh_stall", stalls, 5);
        chk("lh_be", {28'd0, obs_be}, 32'hC);

        // LW pass-through
        do_access(1, 0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 1);
        chk("lw_data", done_rdata, 32'hDEAD_BEEF);
        chk("lw_stall", stalls, 5);

        // LBU 0x101, lane 1 zero-extended
        do_access(1, 0, F3_BU, 32'h101, 32'h0, 32'h0000_9A00, 0, 0);
        chk("lbu_data", done_rdata, 32'h0000_009A);

        // illegal funct3 load: no bus, one stall cycle, data kept
        do_access(1, 0, 3'b111, 32'h200, 32'h0, 32'hFFFF_FFFF, 0, 0);
        chk("ill_noreq", {31'd0, req_seen}, 32'd0);
        chk("ill_stall", stalls, 1);
        chk("ill_keep_rd", done_rdata, 32'h0000_009A);
        chk("ill_mis", {31'd0, done_mis}, 32'd0);

        // SH at 0x306
        do_access(0, 1, F3_H, 32'h306, 32'h0000_CAFE, 32'h0, 0, 0);
        chk("sh_be", {28'd0, obs_be}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hCAFE_CAFE);
        chk("sh_stall", stalls, 2);

        // read and write both high: behaves as a store
        do_access(1, 1, F3_W, 32'h40, 32'h5555_AAAA, 32'h0, 0, 0);
        chk("rw_we", {31'd0, obs_we}, 32'd1);
        chk("rw_stall", stalls, 2);
        chk("rw_keep_rd", done_rdata, 32'h0000_009A);

        // reset in RESP, then stray rvalid
        MemReadM = 1'b1; Funct3M = F3_W; ALUResultM = 32'h500;
        @(negedge clk);
        #1 dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        #1 dmem_bus.dmem_ready = 1'b0;
        chk("rr_resp_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rr_resp_stall", {31'd0, StallM}, 32'd1);
        rst = 1'b1;
        MemReadM = 1'b0;
        #1;
        chk("rr_rdata", ReadDataM, 32'h0);
        chk("rr_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        #1;
        chk("rr_stray_rd", ReadDataM, 32'h0);
        chk("rr_stray_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        MemReadM = 1'b1;
        #1;
        chk("rr_idle_stall", {31'd0, StallM}, 32'd1);
        @(negedge clk);
        #1;
        chk("rr_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        chk("rr_req_rd", ReadDataM, 32'h0);
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_ready  = 1'b1;
        @(negedge clk);
        #1;
        dmem_bus.dmem_ready  = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'hA5A5_A5A5;
        @(negedge clk);
        #1;
        dmem_bus.dmem_rvalid = 1'b0;
        chk("rr_done_stall", {31'd0, StallM}, 32'd0);
        chk("rr_done_rd", ReadDataM, 32'hA5A5_A5A5);
        MemReadM = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
